result_demux3: RTL

- Registered 1-to-3 demultiplexer. It is the distribution counterpart of the 3:1 result-select multiplexer.
- Takes a single 32-bit word stream, tagged with a 2-bit selection, and routes each word to one of three destination channels.
- Each destination has its own small FIFO and a valid/ready handshake, so a stalled destination does not block traffic to the others once its word is buffered.
- Sits between the datapath result source and the writeback, store and forward consumers.

---
 rtl/result_demux3.sv | 114 +++++++++++
 1 files changed

// File: rtl/result_demux3.sv
// Registered 1-to-3 demultiplexer: routes tagged words into three independent
// per-destination FIFOs with valid/ready outputs; selection 3 is counted and dropped.
module result_demux3 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [1:0]            selection,
    output logic                  out0_valid,
    output logic                  out1_valid,
    output logic                  out2_valid,
    input  logic                  out0_ready,
    input  logic                  out1_ready,
    input  logic                  out2_ready,
    output logic [DATA_WIDTH-1:0] out0_data,
    output logic [DATA_WIDTH-1:0] out1_data,
    output logic [DATA_WIDTH-1:0] out2_data,
    output logic [CNT_WIDTH-1:0]  drop_count,
    output logic                  sel_error
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q  [3][DEPTH];
    logic [DATA_WIDTH-1:0] last_q [3];
    logic [PW-1:0]         wptr_q [3];
    logic [PW-1:0]         rptr_q [3];
    logic [CW-1:0]         cnt_q  [3];
    logic [CNT_WIDTH-1:0]  drop_q;
    logic                  err_q;

    logic [2:0]            full, empty, push, pop, out_ready;
    logic                  sel_full, accept, drop;
    logic [DATA_WIDTH-1:0] head [3];

    assign out_ready = {out2_ready, out1_ready, out0_ready};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            full[i]  = (cnt_q[i] == FullCnt);
            empty[i] = (cnt_q[i] == '0);
            // An empty channel shows the last word it handed out.
            head[i]  = empty[i] ? last_q[i] : mem_q[i][rptr_q[i]];
        end
        case (selection)
            2'd0:    sel_full = full[0];
            2'd1:    sel_full = full[1];
            2'd2:    sel_full = full[2];
            default: sel_full = 1'b0;
        endcase
        in_ready = !rst && !sel_full;
        accept   = in_valid && in_ready;
        drop     = accept && (selection == 2'd3);
        for (int i = 0; i < 3; i++) begin
            push[i] = accept && (selection == 2'(i));
            pop[i]  = !empty[i] && out_ready[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                for (int d = 0; d < int'(DEPTH); d++) begin
                    mem_q[i][d] <= '0;
                end
                last_q[i] <= '0;
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            drop_q <= '0;
            err_q  <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (push[i]) begin
                    mem_q[i][wptr_q[i]] <= in_data;
                    wptr_q[i]           <= wptr_q[i] + PW'(1);
                end
                if (pop[i]) begin
                    rptr_q[i] <= rptr_q[i] + PW'(1);
                    last_q[i] <= head[i];
                end
                if (push[i] && !pop[i]) begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end else if (pop[i] && !push[i]) begin
                    cnt_q[i] <= cnt_q[i] - CW'(1);
                end
            end
            if (drop) begin
                err_q <= 1'b1;
                if (drop_q != '1) begin
                    drop_q <= drop_q + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign out0_valid = !empty[0];
    assign out1_valid = !empty[1];
    assign out2_valid = !empty[2];
    assign out0_data  = head[0];
    assign out1_data  = head[1];
    assign out2_data  = head[2];
    assign drop_count = drop_q;
    assign sel_error  = err_q;

endmodule
